// File: rtl/gpu_bg_block_mem.sv
// Background-block memory sequencer: saves the outgoing BG block to VRAM under
// its pixel mask, optionally reloads the next block for blending, then acks the
// backend. VRAM traffic is 8 beats of 32 bits (2 pixels) per 256-bit block.
module gpu_bg_block_mem (
  input  logic         clk,
  input  logic         i_nrst,
  input  logic [1:0]   i_saveBGBlock,
  input  logic [14:0]  i_loadAdr,
  input  logic [14:0]  i_saveAdr,
  input  logic [255:0] i_exportedBGBlock,
  input  logic [15:0]  i_exportedMSKBGBlock,
  input  logic         i_blendEnable,
  output logic         o_pausePipeline,
  output logic         o_resetPipelinePixelStateSpike,
  output logic         o_resetPixelMask,
  output logic         o_importBGBlockSingleClock,
  output logic [255:0] o_importedBGBlock,
  output logic         o_flushDone,
  output logic         o_memCmdValid,
  input  logic         i_memCmdReady,
  output logic         o_memCmdWrite,
  output logic [14:0]  o_memCmdAdr,
  output logic         o_memWrValid,
  input  logic         i_memWrReady,
  output logic [31:0]  o_memWrData,
  output logic [1:0]   o_memWrMask,
  input  logic         i_memRdValid,
  input  logic [31:0]  i_memRdData
);

  localparam int unsigned ADR_W   = 15;
  localparam int unsigned BEAT_W  = 32;
  localparam int unsigned BLOCK_W = 256;
  localparam int unsigned MASK_W  = 16;
  localparam int unsigned CNT_W   = 3;

  localparam logic [1:0]       OP_NONE   = 2'b00;
  localparam logic [1:0]       OP_FIRST  = 2'b01;
  localparam logic [1:0]       OP_NEXT   = 2'b10;
  localparam logic [1:0]       OP_FLUSH  = 2'b11;
  localparam logic [CNT_W-1:0] LAST_BEAT = 3'd7;

  typedef enum logic [2:0] {
    IDLE, WCMD, WDATA, RCMD, RDATA, IMPORT, ACK, FLUSHED
  } state_t;

  state_t             state;
  state_t             postNext;
  logic [1:0]         opCode;
  logic [ADR_W-1:0]   loadAdrLat;
  logic [BLOCK_W-1:0] blockLat;
  logic [MASK_W-1:0]  maskLat;
  logic               blendLat;
  logic [CNT_W-1:0]   beatCnt;
  logic [CNT_W-1:0]   nextBeat;
  logic [1:0]         curCode;
  logic               curBlend;
  logic [ADR_W-1:0]   curLoadAdr;
  logic               doPost;

  // Stall is combinational so the pixel carrying the new-block flag is held at once.
  assign o_pausePipeline = (state != IDLE) | (i_saveBGBlock != OP_NONE);

  assign nextBeat = CNT_W'(beatCnt + 3'd1);

  // Op parameters: live inputs on the IDLE exit cycle, latched copies afterwards.
  always_comb begin
    curCode    = opCode;
    curBlend   = blendLat;
    curLoadAdr = loadAdrLat;
    if (state == IDLE) begin
      curCode    = i_saveBGBlock;
      curBlend   = i_blendEnable;
      curLoadAdr = i_loadAdr;
    end
  end

  // Post-write step: where to go once the write is finished or skipped.
  always_comb begin
    postNext = ACK;
    if (curCode == OP_FLUSH) begin
      postNext = FLUSHED;
    end else if (curBlend) begin
      postNext = RCMD;
    end
    doPost = 1'b0;
    if ((state == IDLE) && ((i_saveBGBlock == OP_NEXT) || (i_saveBGBlock == OP_FLUSH)) &&
        (i_exportedMSKBGBlock == '0)) begin
      doPost = 1'b1;
    end
    if ((state == WDATA) && o_memWrValid && i_memWrReady && (beatCnt == LAST_BEAT)) begin
      doPost = 1'b1;
    end
  end

  // Sequencer FSM with registered memory-interface outputs and pulses.
  always_ff @(posedge clk) begin
    if (!i_nrst) begin
      state                          <= IDLE;
      opCode                         <= OP_NONE;
      loadAdrLat                     <= '0;
      blockLat                       <= '0;
      maskLat                        <= '0;
      blendLat                       <= 1'b0;
      beatCnt                        <= '0;
      o_importedBGBlock              <= '0;
      o_resetPipelinePixelStateSpike <= 1'b0;
      o_resetPixelMask               <= 1'b0;
      o_importBGBlockSingleClock     <= 1'b0;
      o_flushDone                    <= 1'b0;
      o_memCmdValid                  <= 1'b0;
      o_memCmdWrite                  <= 1'b0;
      o_memCmdAdr                    <= '0;
      o_memWrValid                   <= 1'b0;
      o_memWrData                    <= '0;
      o_memWrMask                    <= '0;
    end else begin
      o_resetPipelinePixelStateSpike <= 1'b0;
      o_resetPixelMask               <= 1'b0;
      o_importBGBlockSingleClock     <= 1'b0;

      case (state)
        IDLE: begin
          if (i_saveBGBlock != OP_NONE) begin
            opCode     <= i_saveBGBlock;
            loadAdrLat <= i_loadAdr;
            blockLat   <= i_exportedBGBlock;
            maskLat    <= i_exportedMSKBGBlock;
            blendLat   <= i_blendEnable;
            if (i_saveBGBlock == OP_FIRST) begin
              if (i_blendEnable) begin
                state         <= RCMD;
                o_memCmdValid <= 1'b1;
                o_memCmdWrite <= 1'b0;
                o_memCmdAdr   <= i_loadAdr;
              end else begin
                state <= ACK;
              end
            end else if (i_exportedMSKBGBlock != '0) begin
              state         <= WCMD;
              o_memCmdValid <= 1'b1;
              o_memCmdWrite <= 1'b1;
              o_memCmdAdr   <= i_saveAdr;
            end
          end
        end
        WCMD: begin
          if (i_memCmdReady) begin
            o_memCmdValid <= 1'b0;
            state         <= WDATA;
            beatCnt       <= '0;
            o_memWrValid  <= 1'b1;
            o_memWrData   <= blockLat[BEAT_W-1:0];
            o_memWrMask   <= maskLat[1:0];
          end
        end
        WDATA: begin
          if (i_memWrReady) begin
            if (beatCnt == LAST_BEAT) begin
              o_memWrValid <= 1'b0;
              beatCnt      <= '0;
            end else begin
              beatCnt     <= nextBeat;
              o_memWrData <= blockLat[{nextBeat, 5'd0} +: BEAT_W];
              o_memWrMask <= maskLat[{nextBeat, 1'b0} +: 2];
            end
          end
        end
        RCMD: begin
          if (i_memCmdReady) begin
            o_memCmdValid <= 1'b0;
            state         <= RDATA;
            beatCnt       <= '0;
          end
        end
        RDATA: begin
          if (i_memRdValid) begin
            o_importedBGBlock[{beatCnt, 5'd0} +: BEAT_W] <= i_memRdData;
            beatCnt <= nextBeat;
            if (beatCnt == LAST_BEAT) begin
              state                      <= IMPORT;
              o_importBGBlockSingleClock <= 1'b1;
            end
          end
        end
        IMPORT: begin
          state <= ACK;
        end
        ACK: begin
          state                          <= IDLE;
          o_resetPipelinePixelStateSpike <= 1'b1;
        end
        FLUSHED: begin
          if (i_saveBGBlock != OP_FLUSH) begin
            state       <= IDLE;
            o_flushDone <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase

      // Write finished or skipped: clear the pixel mask and take the post-write step.
      if (doPost) begin
        state            <= postNext;
        o_resetPixelMask <= 1'b1;
        if (postNext == RCMD) begin
          o_memCmdValid <= 1'b1;
          o_memCmdWrite <= 1'b0;
          o_memCmdAdr   <= curLoadAdr;
        end
        if (postNext == FLUSHED) begin
          o_flushDone <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_gpu_bg_block_mem.sv
// Scoreboard bench for gpu_bg_block_mem: expected commands/beats are queued as
// stimulus is issued and compared as the DUT hands them over.
module tb_gpu_bg_block_mem;

  logic         clk;
  logic         i_nrst;
  logic [1:0]   i_saveBGBlock;
  logic [14:0]  i_loadAdr;
  logic [14:0]  i_saveAdr;
  logic [255:0] i_exportedBGBlock;
  logic [15:0]  i_exportedMSKBGBlock;
  logic         i_blendEnable;
  logic         o_pausePipeline;
  logic         o_resetPipelinePixelStateSpike;
  logic         o_resetPixelMask;
  logic         o_importBGBlockSingleClock;
  logic [255:0] o_importedBGBlock;
  logic         o_flushDone;
  logic         o_memCmdValid;
  logic         i_memCmdReady;
  logic         o_memCmdWrite;
  logic [14:0]  o_memCmdAdr;
  logic         o_memWrValid;
  logic         i_memWrReady;
  logic [31:0]  o_memWrData;
  logic [1:0]   o_memWrMask;
  logic         i_memRdValid;
  logic [31:0]  i_memRdData;

  gpu_bg_block_mem dut (
    .clk(clk), .i_nrst(i_nrst), .i_saveBGBlock(i_saveBGBlock),
    .i_loadAdr(i_loadAdr), .i_saveAdr(i_saveAdr),
    .i_exportedBGBlock(i_exportedBGBlock), .i_exportedMSKBGBlock(i_exportedMSKBGBlock),
    .i_blendEnable(i_blendEnable), .o_pausePipeline(o_pausePipeline),
    .o_resetPipelinePixelStateSpike(o_resetPipelinePixelStateSpike),
    .o_resetPixelMask(o_resetPixelMask),
    .o_importBGBlockSingleClock(o_importBGBlockSingleClock),
    .o_importedBGBlock(o_importedBGBlock), .o_flushDone(o_flushDone),
    .o_memCmdValid(o_memCmdValid), .i_memCmdReady(i_memCmdReady),
    .o_memCmdWrite(o_memCmdWrite), .o_memCmdAdr(o_memCmdAdr),
    .o_memWrValid(o_memWrValid), .i_memWrReady(i_memWrReady),
    .o_memWrData(o_memWrData), .o_memWrMask(o_memWrMask),
    .i_memRdValid(i_memRdValid), .i_memRdData(i_memRdData)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int nChecks, nPass, cyc;
  logic [15:0] cmdExpQ[$];
  logic [33:0] wrExpQ[$];
  int cmdCnt, rdCmdCnt, wrCnt, maskCnt, importCnt, spikeCnt;
  int maskCyc, importCyc, spikeCyc;
  logic spikePause;
  logic [255:0] lastImport;
  logic cmdPend, wrPend;
  logic [15:0] cmdHold;
  logic [33:0] wrHold;
  logic rdArm;
  int rdSent;
  logic [31:0] rdBase;

  // Sample the cycle about to be clocked: handshakes, stability, pulses.
  task automatic monitor();
    logic [15:0] c, e16;
    logic [33:0] w, e34;
    c = {o_memCmdWrite, o_memCmdAdr};
    w = {o_memWrMask, o_memWrData};
    if (!i_nrst) begin
      cmdPend = 1'b0;
      wrPend  = 1'b0;
      return;
    end
    if (cmdPend) begin
      nChecks++;
      if (!o_memCmdValid || c !== cmdHold) $display("FAIL cmd_stable got v=%b %h want v=1 %h", o_memCmdValid, c, cmdHold);
      else nPass++;
    end
    if (wrPend) begin
      nChecks++;
      if (!o_memWrValid || w !== wrHold) $display("FAIL wr_stable got v=%b %h want v=1 %h", o_memWrValid, w, wrHold);
      else nPass++;
    end
    if (o_memCmdValid && i_memCmdReady) begin
      cmdCnt++;
      if (!o_memCmdWrite) begin rdCmdCnt++; rdArm = 1'b1; rdSent = 0; end
      nChecks++;
      if (cmdExpQ.size() == 0) $display("FAIL cmd_unexpected got %h want none", c);
      else begin
        e16 = cmdExpQ.pop_front();
        if (c !== e16) $display("FAIL cmd got %h want %h", c, e16);
        else nPass++;
      end
    end
    if (o_memWrValid && i_memWrReady) begin
      wrCnt++;
      nChecks++;
      if (wrExpQ.size() == 0) $display("FAIL wr_unexpected got %h want none", w);
      else begin
        e34 = wrExpQ.pop_front();
        if (w !== e34) $display("FAIL wr_beat got %h want %h", w, e34);
        else nPass++;
      end
    end
    cmdPend = o_memCmdValid && !i_memCmdReady;
    cmdHold = c;
    wrPend  = o_memWrValid && !i_memWrReady;
    wrHold  = w;
    if (o_resetPixelMask) begin maskCnt++; maskCyc = cyc; end
    if (o_importBGBlockSingleClock) begin importCnt++; importCyc = cyc; lastImport = o_importedBGBlock; end
    if (o_resetPipelinePixelStateSpike) begin spikeCnt++; spikeCyc = cyc; spikePause = o_pausePipeline; end
  endtask

  // Advance one clock; read memory model serves 8 beats after a read command.
  task automatic next();
    monitor();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (rdArm && rdSent < 8) begin
      i_memRdValid = 1'b1;
      i_memRdData  = rdBase + 32'(rdSent);
      rdSent++;
    end else begin
      i_memRdValid = 1'b0;
      rdArm = 1'b0;
    end
  endtask

  task automatic start_op(input logic [1:0] code, input logic [14:0] la, input logic [14:0] sa,
                          input logic [255:0] blk, input logic [15:0] msk, input logic bl,
                          input logic hold, output int c0);
    i_saveBGBlock = code; i_loadAdr = la; i_saveAdr = sa;
    i_exportedBGBlock = blk; i_exportedMSKBGBlock = msk; i_blendEnable = bl;
    #1;
    nChecks++;
    if (o_pausePipeline !== 1'b1) $display("FAIL pause_comb got %b want 1", o_pausePipeline);
    else nPass++;
    next();
    c0 = cyc;
    if (!hold) i_saveBGBlock = 2'b00;
    i_loadAdr = ~la; i_saveAdr = ~sa; i_exportedBGBlock = ~blk;
    i_exportedMSKBGBlock = ~msk; i_blendEnable = ~bl;
  endtask

  task automatic push_write(input logic [14:0] sa, input logic [255:0] blk, input logic [15:0] msk);
    cmdExpQ.push_back({1'b1, sa});
    for (int k = 0; k < 8; k++) wrExpQ.push_back({msk[2*k +: 2], blk[32*k +: 32]});
  endtask

  task automatic wait_spike(input int s0, input int limit, input logic toggleWr);
    int n = 0;
    while (spikeCnt == s0 && n < limit) begin
      if (toggleWr) i_memWrReady = ~i_memWrReady;
      next();
      n++;
    end
    nChecks++;
    if (spikeCnt == s0) $display("FAIL spike_timeout got none want pulse within %0d cycles", limit);
    else nPass++;
    i_memWrReady = 1'b1;
    next();
    next();
  endtask

  task automatic test_reset();
    i_nrst = 1'b0;
    next();
    next();
    nChecks++;
    if ({o_memCmdValid, o_memWrValid, o_resetPipelinePixelStateSpike, o_resetPixelMask,
         o_importBGBlockSingleClock, o_flushDone, o_pausePipeline} !== 7'b0)
      $display("FAIL reset_outputs got %b want 0000000", {o_memCmdValid, o_memWrValid,
               o_resetPipelinePixelStateSpike, o_resetPixelMask, o_importBGBlockSingleClock,
               o_flushDone, o_pausePipeline});
    else nPass++;
    nChecks++;
    if (o_importedBGBlock !== 256'h0) $display("FAIL reset_imported got %h want 0", o_importedBGBlock);
    else nPass++;
    i_nrst = 1'b1;
    next();
  endtask

  task automatic test_load();
    int c0, s0, i0, m0, r0, w0, k0;
    logic [255:0] expBlk;
    s0 = spikeCnt; i0 = importCnt; m0 = maskCnt; r0 = rdCmdCnt; w0 = wrCnt; k0 = cmdCnt;
    for (int k = 0; k < 8; k++) expBlk[32*k +: 32] = 32'h00010000 + 32'(k);
    i_memRdValid = 1'b1; i_memRdData = 32'hDEADBEEF;
    next();
    cmdExpQ.push_back({1'b0, 15'h0123});
    rdBase = 32'h00010000;
    start_op(2'b01, 15'h0123, 15'h0555, '1, 16'hFFFF, 1'b1, 1'b0, c0);
    wait_spike(s0, 60, 1'b0);
    nChecks++; if (cmdCnt - k0 != 1 || rdCmdCnt - r0 != 1) $display("FAIL load_cmds got %0d/%0d want 1/1", cmdCnt - k0, rdCmdCnt - r0); else nPass++;
    nChecks++; if (wrCnt - w0 != 0) $display("FAIL load_no_write got %0d want 0", wrCnt - w0); else nPass++;
    nChecks++; if (importCnt - i0 != 1 || spikeCnt - s0 != 1 || maskCnt - m0 != 0) $display("FAIL load_pulses got i%0d s%0d m%0d want i1 s1 m0", importCnt - i0, spikeCnt - s0, maskCnt - m0); else nPass++;
    nChecks++; if (importCyc - c0 != 9 || spikeCyc - importCyc != 2) $display("FAIL load_timing got %0d,%0d want 9,2", importCyc - c0, spikeCyc - importCyc); else nPass++;
    nChecks++; if (lastImport[31:0] !== 32'h00010000) $display("FAIL load_beat0 got %h want 00010000", lastImport[31:0]); else nPass++;
    nChecks++; if (lastImport[255:224] !== 32'h00010007) $display("FAIL load_beat7 got %h want 00010007", lastImport[255:224]); else nPass++;
    nChecks++; if (lastImport !== expBlk) $display("FAIL load_block got %h want %h", lastImport, expBlk); else nPass++;
    nChecks++; if (spikePause !== 1'b0) $display("FAIL load_pause_fall got %b want 0", spikePause); else nPass++;
    nChecks++; if (cmdExpQ.size() != 0) $display("FAIL load_pending got %0d want 0", cmdExpQ.size()); else nPass++;
  endtask

  task automatic test_save_noblend();
    int c0, s0, m0, r0, w0;
    logic [255:0] blk;
    for (int k = 0; k < 8; k++) blk[32*k +: 32] = $urandom;
    s0 = spikeCnt; m0 = maskCnt; r0 = rdCmdCnt; w0 = wrCnt;
    push_write(15'h0040, blk, 16'h8001);
    start_op(2'b10, 15'h0777, 15'h0040, blk, 16'h8001, 1'b0, 1'b0, c0);
    wait_spike(s0, 60, 1'b0);
    nChecks++; if (wrCnt - w0 != 8) $display("FAIL save_beats got %0d want 8", wrCnt - w0); else nPass++;
    nChecks++; if (rdCmdCnt - r0 != 0) $display("FAIL save_no_read got %0d want 0", rdCmdCnt - r0); else nPass++;
    nChecks++; if (maskCnt - m0 != 1 || spikeCnt - s0 != 1) $display("FAIL save_pulses got m%0d s%0d want m1 s1", maskCnt - m0, spikeCnt - s0); else nPass++;
    nChecks++; if (maskCyc - c0 != 9 || spikeCyc - maskCyc != 1) $display("FAIL save_timing got %0d,%0d want 9,1", maskCyc - c0, spikeCyc - maskCyc); else nPass++;
    nChecks++; if (wrExpQ.size() != 0 || cmdExpQ.size() != 0) $display("FAIL save_pending got %0d want 0", wrExpQ.size() + cmdExpQ.size()); else nPass++;
  endtask

  task automatic test_skip_blend();
    int c0, s0, i0, m0, w0;
    logic [255:0] expBlk;
    for (int k = 0; k < 8; k++) expBlk[32*k +: 32] = 32'h00020000 + 32'(k);
    s0 = spikeCnt; i0 = importCnt; m0 = maskCnt; w0 = wrCnt;
    cmdExpQ.push_back({1'b0, 15'h2ABC});
    rdBase = 32'h00020000;
    start_op(2'b10, 15'h2ABC, 15'h0100, '1, 16'h0000, 1'b1, 1'b0, c0);
    wait_spike(s0, 60, 1'b0);
    nChecks++; if (wrCnt - w0 != 0) $display("FAIL skip_no_write got %0d want 0", wrCnt - w0); else nPass++;
    nChecks++; if (maskCnt - m0 != 1 || importCnt - i0 != 1 || spikeCnt - s0 != 1) $display("FAIL skip_pulses got m%0d i%0d s%0d want 1 1 1", maskCnt - m0, importCnt - i0, spikeCnt - s0); else nPass++;
    nChecks++; if (!(maskCyc < importCyc && importCyc < spikeCyc)) $display("FAIL skip_order got %0d,%0d,%0d want increasing", maskCyc, importCyc, spikeCyc); else nPass++;
    nChecks++; if (lastImport !== expBlk) $display("FAIL skip_block got %h want %h", lastImport, expBlk); else nPass++;
  endtask

  task automatic test_flush();
    int c0, s0, m0, w0, n;
    logic [255:0] blk;
    for (int k = 0; k < 8; k++) blk[32*k +: 32] = $urandom;
    s0 = spikeCnt; m0 = maskCnt; w0 = wrCnt; n = 0;
    push_write(15'h1ABC, blk, 16'hFFFF);
    start_op(2'b11, 15'h0001, 15'h1ABC, blk, 16'hFFFF, 1'b1, 1'b1, c0);
    while (!o_flushDone && n < 40) begin next(); n++; end
    for (int h = 0; h < 3; h++) begin
      nChecks++;
      if (o_flushDone !== 1'b1 || o_pausePipeline !== 1'b1) $display("FAIL flush_hold got done=%b pause=%b want 1 1", o_flushDone, o_pausePipeline);
      else nPass++;
      next();
    end
    nChecks++; if (wrCnt - w0 != 8 || maskCnt - m0 != 1) $display("FAIL flush_write got w%0d m%0d want w8 m1", wrCnt - w0, maskCnt - m0); else nPass++;
    i_saveBGBlock = 2'b00;
    next();
    nChecks++; if (o_flushDone !== 1'b0 || o_pausePipeline !== 1'b0) $display("FAIL flush_exit got done=%b pause=%b want 0 0", o_flushDone, o_pausePipeline); else nPass++;
    next(); next(); next();
    nChecks++; if (spikeCnt - s0 != 0) $display("FAIL flush_no_spike got %0d want 0", spikeCnt - s0); else nPass++;
  endtask

  task automatic test_backpressure();
    int c0, s0, w0, k0;
    logic [255:0] blk;
    logic [15:0] msk;
    for (int k = 0; k < 8; k++) blk[32*k +: 32] = $urandom;
    msk = 16'($urandom) | 16'h0001;
    s0 = spikeCnt; w0 = wrCnt; k0 = cmdCnt;
    push_write(15'h3001, blk, msk);
    i_memCmdReady = 1'b0;
    start_op(2'b10, 15'h0002, 15'h3001, blk, msk, 1'b0, 1'b0, c0);
    for (int h = 0; h < 5; h++) next();
    nChecks++; if (cmdCnt - k0 != 0 || o_memCmdValid !== 1'b1) $display("FAIL bp_cmd_held got acc=%0d v=%b want 0 1", cmdCnt - k0, o_memCmdValid); else nPass++;
    i_memCmdReady = 1'b1;
    wait_spike(s0, 100, 1'b1);
    nChecks++; if (wrCnt - w0 != 8) $display("FAIL bp_beats got %0d want 8", wrCnt - w0); else nPass++;
    nChecks++; if (wrExpQ.size() != 0 || cmdExpQ.size() != 0) $display("FAIL bp_pending got %0d want 0", wrExpQ.size() + cmdExpQ.size()); else nPass++;
  endtask

  task automatic test_reset_midtransfer();
    int c0, w0, m0, i0, s0, k0, n;
    logic [255:0] blk;
    for (int k = 0; k < 8; k++) blk[32*k +: 32] = $urandom;
    w0 = wrCnt; n = 0;
    push_write(15'h0111, blk, 16'hFFFF);
    start_op(2'b10, 15'h0AAA, 15'h0111, blk, 16'hFFFF, 1'b1, 1'b0, c0);
    while (wrCnt - w0 < 3 && n < 30) begin next(); n++; end
    nChecks++; if (wrCnt - w0 != 3 || o_memWrValid !== 1'b1) $display("FAIL rst_reach_beat3 got %0d v=%b want 3 1", wrCnt - w0, o_memWrValid); else nPass++;
    i_nrst = 1'b0; i_memWrReady = 1'b0;
    next();
    nChecks++;
    if ({o_memCmdValid, o_memWrValid, o_resetPipelinePixelStateSpike, o_resetPixelMask,
         o_importBGBlockSingleClock, o_flushDone, o_pausePipeline} !== 7'b0)
      $display("FAIL rst_mid_outputs got %b want 0000000", {o_memCmdValid, o_memWrValid,
               o_resetPipelinePixelStateSpike, o_resetPixelMask, o_importBGBlockSingleClock,
               o_flushDone, o_pausePipeline});
    else nPass++;
    nChecks++; if (o_importedBGBlock !== 256'h0) $display("FAIL rst_mid_imported got %h want 0", o_importedBGBlock); else nPass++;
    i_nrst = 1'b1; i_memWrReady = 1'b1;
    wrExpQ.delete(); cmdExpQ.delete();
    w0 = wrCnt; m0 = maskCnt; i0 = importCnt; s0 = spikeCnt; k0 = cmdCnt;
    for (int h = 0; h < 12; h++) next();
    nChecks++;
    if (wrCnt != w0 || maskCnt != m0 || importCnt != i0 || spikeCnt != s0 || cmdCnt != k0)
      $display("FAIL rst_abandon got w%0d m%0d i%0d s%0d c%0d want 0 0 0 0 0", wrCnt - w0, maskCnt - m0, importCnt - i0, spikeCnt - s0, cmdCnt - k0);
    else nPass++;
  endtask

  initial begin
    nChecks = 0; nPass = 0; cyc = 0;
    cmdCnt = 0; rdCmdCnt = 0; wrCnt = 0; maskCnt = 0; importCnt = 0; spikeCnt = 0;
    maskCyc = 0; importCyc = 0; spikeCyc = 0; spikePause = 1'b0; lastImport = '0;
    cmdPend = 1'b0; wrPend = 1'b0; cmdHold = '0; wrHold = '0;
    rdArm = 1'b0; rdSent = 0; rdBase = '0;
    i_nrst = 1'b0; i_saveBGBlock = 2'b00; i_loadAdr = '0; i_saveAdr = '0;
    i_exportedBGBlock = '0; i_exportedMSKBGBlock = '0; i_blendEnable = 1'b0;
    i_memCmdReady = 1'b1; i_memWrReady = 1'b1; i_memRdValid = 1'b0; i_memRdData = '0;
    @(negedge clk);
    test_reset();
    test_load();
    test_save_noblend();
    test_skip_blend();
    test_flush();
    test_backpressure();
    test_reset_midtransfer();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/gpu_bg_block_mem.md
# gpu_bg_block_mem

Background-block memory sequencer sitting directly downstream of the GPU backend's 16-pixel BG cache line. It watches the 2-bit block-operation code, stalls the pixel pipeline, and writes the outgoing 256-bit block back to VRAM under its 16-bit pixel mask. It then optionally reads the next block for blending, hands it back in a single-clock import, and finally clears the backend's block-state flags. VRAM traffic uses a 32-bit beat interface: 8 beats per block, 2 pixels per beat.

## Interface
No parameters.

- clk  in  1  system clock; all logic on rising edge
- i_nrst  in  1  reset, synchronous, active-low
- i_saveBGBlock  in  2  block-op code: 00 none, 01 first block, 10 next block, 11 flush
- i_loadAdr  in  15  block address {y[8:0], x[9:4]} of the block to load
- i_saveAdr  in  15  block address of the block to save
- i_exportedBGBlock  in  256  outgoing block; pixel p at [16p+15:16p]
- i_exportedMSKBGBlock  in  16  per-pixel write mask; bit p = pixel p
- i_blendEnable  in  1  1 = load BG after save (transparency active)
- o_pausePipeline  out  1  stall to backend
- o_resetPipelinePixelStateSpike  out  1  one-cycle pulse; clears the backend block flag
- o_resetPixelMask  out  1  one-cycle pulse; clears the backend pixel mask
- o_importBGBlockSingleClock  out  1  one-cycle pulse; o_importedBGBlock is valid
- o_importedBGBlock  out  256  assembled loaded block
- o_flushDone  out  1  level; flush complete
- o_memCmdValid  out  1  command request
- i_memCmdReady  in  1  command accepted when valid & ready
- o_memCmdWrite  out  1  1 = write, 0 = read
- o_memCmdAdr  out  15  block address
- o_memWrValid  out  1  write beat valid
- i_memWrReady  in  1  beat accepted when valid & ready
- o_memWrData  out  32  beat data
- o_memWrMask  out  2  beat pixel enables; [0] = low halfword
- i_memRdValid  in  1  read beat present (no backpressure)
- i_memRdData  in  32  read beat data

## Operation
- States: IDLE, WCMD, WDATA, RCMD, RDATA, IMPORT, ACK, FLUSHED.
- The op code, addresses, mask and block are latched on the IDLE exit cycle. Later input changes are ignored until the state returns to IDLE.
- IDLE, code 00: stay.
- IDLE, code 01:
  - blendEnable = 1: go to RCMD with load address.
  - blendEnable = 0: go to ACK.
- IDLE, code 10 or 11:
  - latched mask ≠ 0: go to WCMD.
  - latched mask = 0: skip the write; go to the post-write step.
- WCMD: o_memCmdValid = 1, write = 1, adr = saveAdr. On handshake go to WDATA with the beat counter at 0.
- WDATA:
  - Beat k drives data = block[32k+31:32k] and mask = MSK[2k+1:2k].
  - The counter advances only on handshake.
  - After beat 7 is accepted, pulse o_resetPixelMask for one cycle and do the post-write step.
- Post-write step:
  - Code 10 with blendEnable = 1: go to RCMD with load address.
  - Code 10 with blendEnable = 0: go to ACK.
  - Code 11: go to FLUSHED. The pixel-mask pulse is still issued when the write was skipped.
- RCMD: read command, adr = loadAdr. On handshake go to RDATA.
- RDATA:
  - Beat k is stored to o_importedBGBlock[32k+31:32k] on each i_memRdValid.
  - After beat 7 go to IMPORT.
- IMPORT: pulse o_importBGBlockSingleClock for one cycle; go to ACK.
- ACK: pulse o_resetPipelinePixelStateSpike for one cycle; go to IDLE.
- FLUSHED:
  - o_flushDone = 1 and o_pausePipeline = 1.
  - Exit to IDLE when i_saveBGBlock ≠ 11, with no state-spike pulse.
- Read beats arriving outside RDATA are dropped.

## Timing
- o_pausePipeline = (state ≠ IDLE) | (state = IDLE & i_saveBGBlock ≠ 00). This is combinational, so the pixel carrying the new-block flag is held on that very cycle.
- Reset: state IDLE, beat counter 0, o_importedBGBlock = 0.
- Output values at reset:
  - Registered outputs, all 0: o_memCmdValid, o_memWrValid, o_resetPipelinePixelStateSpike, o_resetPixelMask, o_importBGBlockSingleClock, o_flushDone.
  - o_pausePipeline follows its combinational formula.
- A reset mid-transfer abandons the transfer. No further beats or pulses are issued.
- Minimum latencies with zero-wait memory:
  - 01 load: IDLE to ACK is 1 + 1 + 8 + 1 cycles. Pause drops the cycle after ACK.
  - 10 save + load: adds 1 + 8 cycles for the write.
- Invariants:
  - All pulses are exactly one cycle wide.
  - The pixel-mask pulse always precedes the import pulse, which precedes the state-spike pulse.
  - o_memCmdValid is held until ready. The address does not change while valid.
  - o_memWrValid is held with stable data/mask until ready.

## Test plan
- Code 01, blendEnable = 1, loadAdr = 0x0123, read beats 0x00010000 + k:
  - 1 read command at 0x0123, no write.
  - imported[31:0] = 0x00010000, imported[255:224] = 0x00010007.
  - import pulse, then spike pulse; pause falls after ACK.
- Code 10, mask = 0x8001, saveAdr = 0x0040, blend = 0:
  - write command at 0x0040.
  - beat 0 mask = 01, beats 1–6 mask = 00, beat 7 mask = 10.
  - mask pulse, spike pulse, no read command.
- Code 10, mask = 0x0000, blend = 1:
  - no write command.
  - mask pulse, then read and import.
- Code 11, mask = 0xFFFF:
  - write with all masks = 11, then o_flushDone = 1, held while code = 11.
  - code drops to 00: IDLE, flushDone = 0, no spike pulse.
- i_memCmdReady low for 5 cycles and i_memWrReady toggling:
  - command and beat data stay stable.
  - exactly 8 beats accepted.
- i_nrst low during WDATA beat 3:
  - next cycle all outputs are at reset values.
  - with code = 00, pause = 0.
